pipe_stage_reg: RTL and testbench

Parametrised pipeline-stage register with valid/ready flow control, a one-entry skid buffer, synchronous flush and x0-write suppression. Replaces the fixed-width, always-advancing stage registers between processor stages (EX/MEM, MEM/WB) so that downstream stalls and branch/exception flushes are handled inside the stage boundary. Payload is NUM_DATA data lanes plus a destination-register index and a control-bit vector.

---
 rtl/pipe_stage_reg_pkg.sv | 9 +
 rtl/pipe_stage_reg_if.sv | 28 ++
 rtl/pipe_stage_reg_slot.sv | 36 +++
 rtl/pipe_stage_reg.sv | 48 ++++
 tb/tb_pipe_stage_reg.sv | 110 +++++++++++
 5 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// pipe_pkg: shared state encoding, control-bit indices and payload sizing for pipe_stage_reg.
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  localparam int CTRL_REG_WRITE = 0;
  localparam int CTRL_MEM_TO_REG = 1;
  function automatic int payload_w(int data_w, int num_data, int rd_w, int ctrl_w);
    return data_w * num_data + rd_w + ctrl_w;
  endfunction
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: upstream/downstream handshake and payload bundle of a pipeline stage.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 64,
  parameter int NUM_DATA = 2,
  parameter int RD_W = 5,
  parameter int CTRL_W = 2
) ();
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [NUM_DATA*DATA_W-1:0] in_data;
  logic [RD_W-1:0] in_rd;
  logic [CTRL_W-1:0] in_ctrl;
  logic out_valid;
  logic out_ready;
  logic [NUM_DATA*DATA_W-1:0] out_data;
  logic [RD_W-1:0] out_rd;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0] occupancy;
  modport master (
    output flush, in_valid, in_data, in_rd, in_ctrl, out_ready,
    input in_ready, out_valid, out_data, out_rd, out_ctrl, occupancy
  );
  modport slave (
    input flush, in_valid, in_data, in_rd, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_rd, out_ctrl, occupancy
  );
endinterface

// File: rtl/pipe_stage_reg_slot.sv
// pipe_slot: one payload register with load enable; drops reg_write on capture when rd is x0.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NUM_DATA = 2,
  parameter int RD_W = 5,
  parameter int CTRL_W = 2,
  parameter bit SUPPRESS_X0 = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic [NUM_DATA*DATA_W-1:0] load_data,
  input  logic [RD_W-1:0] load_rd,
  input  logic [CTRL_W-1:0] load_ctrl,
  output logic [NUM_DATA*DATA_W-1:0] data,
  output logic [RD_W-1:0] rd,
  output logic [CTRL_W-1:0] ctrl
);
  logic [CTRL_W-1:0] ctrl_cap;
  always_comb begin
    ctrl_cap = load_ctrl;
    if (SUPPRESS_X0 && load_rd == '0) ctrl_cap[CTRL_REG_WRITE] = 1'b0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      data <= '0;
      rd <= '0;
      ctrl <= '0;
    end else if (load) begin
      data <= load_data;
      rd <= load_rd;
      ctrl <= ctrl_cap;
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with one-entry skid buffer and flush.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NUM_DATA = 2,
  parameter int RD_W = 5,
  parameter int CTRL_W = 2,
  parameter bit SUPPRESS_X0 = 1'b1
) (
  input logic clk,
  input logic reset,
  pipe_stage_reg_if.slave bus
);
  state_t state;
  logic in_fire, out_fire, main_load, skid_load;
  logic [NUM_DATA*DATA_W-1:0] skid_data;
  logic [RD_W-1:0] skid_rd;
  logic [CTRL_W-1:0] skid_ctrl;
  assign bus.in_ready = state != TWO;
  assign bus.out_valid = state != EMPTY;
  assign bus.occupancy = state == TWO ? 2'd2 : state == ONE ? 2'd1 : 2'd0;
  assign in_fire = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;
  // MAIN refills from SKID when draining TWO, otherwise from the input
  assign main_load = !bus.flush & (state == TWO ? out_fire : in_fire & (state == EMPTY | out_fire));
  assign skid_load = !bus.flush & (state == ONE) & in_fire & !out_fire;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= EMPTY;
    else state <= bus.flush ? EMPTY :
                  state == EMPTY ? (in_fire ? ONE : EMPTY) :
                  state == ONE ? (in_fire & !out_fire ? TWO : !in_fire & out_fire ? EMPTY : ONE) :
                  (out_fire ? ONE : TWO);
  pipe_slot #(.DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .RD_W(RD_W), .CTRL_W(CTRL_W),
              .SUPPRESS_X0(SUPPRESS_X0)) u_skid (
    .clk(clk), .reset(reset), .load(skid_load),
    .load_data(bus.in_data), .load_rd(bus.in_rd), .load_ctrl(bus.in_ctrl),
    .data(skid_data), .rd(skid_rd), .ctrl(skid_ctrl)
  );
  pipe_slot #(.DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .RD_W(RD_W), .CTRL_W(CTRL_W),
              .SUPPRESS_X0(SUPPRESS_X0)) u_main (
    .clk(clk), .reset(reset), .load(main_load),
    .load_data(state == TWO ? skid_data : bus.in_data),
    .load_rd(state == TWO ? skid_rd : bus.in_rd),
    .load_ctrl(state == TWO ? skid_ctrl : bus.in_ctrl),
    .data(bus.out_data), .rd(bus.out_rd), .ctrl(bus.out_ctrl)
  );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg (3x32-bit lanes) plus an unsuppressed x0 instance.
module tb_pipe_stage_reg;
  import pipe_pkg::*;
  localparam int DW = 32, ND = 3, PW = payload_w(DW, ND, 5, 2);
  logic clk = 0, reset = 1;
  int total = 0, bad = 0;
  logic [PW-1:0] q[$];
  logic acc;
  always #5 clk = ~clk;
  pipe_stage_reg_if #(.DATA_W(DW), .NUM_DATA(ND)) bus ();
  pipe_stage_reg_if bus2 ();
  pipe_stage_reg #(.DATA_W(DW), .NUM_DATA(ND), .SUPPRESS_X0(1'b1)) u_dut (.clk(clk), .reset(reset), .bus(bus));
  pipe_stage_reg #(.SUPPRESS_X0(1'b0)) u_nosup (.clk(clk), .reset(reset), .bus(bus2));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] model_of(input logic [ND*DW-1:0] d, input logic [4:0] rd, input logic [1:0] c);
    return {d, rd, rd == 0 ? (c & 2'b10) : c};
  endfunction

  // called at a falling edge: drive, check against the model, advance one clock
  task automatic cycle(input logic v, input logic r, input logic fl, input logic [ND*DW-1:0] d,
                       input logic [4:0] rd, input logic [1:0] c, output logic accepted);
    logic inf, outf;
    bus.in_valid = v; bus.out_ready = r; bus.flush = fl;
    bus.in_data = d; bus.in_rd = rd; bus.in_ctrl = c;
    #1;
    chk("occupancy", 128'(bus.occupancy), 128'(q.size()));
    chk("in_ready", 128'(bus.in_ready), 128'(q.size() != 2));
    chk("out_valid", 128'(bus.out_valid), 128'(q.size() != 0));
    if (q.size() != 0) chk("payload", 128'({bus.out_data, bus.out_rd, bus.out_ctrl}), 128'(q[0]));
    bus.out_ready = !r;
    #1;
    chk("ready_comb", 128'(bus.in_ready), 128'(q.size() != 2));
    bus.out_ready = r;
    inf = v && q.size() < 2;
    outf = r && q.size() != 0;
    accepted = inf && !fl;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back(model_of(d, rd, c));
    end
    @(negedge clk);
  endtask

  initial begin
    bus.in_valid = 0; bus.out_ready = 0; bus.flush = 0;
    bus.in_data = '0; bus.in_rd = '0; bus.in_ctrl = '0;
    bus2.in_valid = 0; bus2.out_ready = 0; bus2.flush = 0;
    bus2.in_data = '0; bus2.in_rd = '0; bus2.in_ctrl = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_occ", 128'(bus.occupancy), 128'(0));
    chk("rst_payload", 128'({bus.out_data, bus.out_rd, bus.out_ctrl}), 128'(0));
    reset = 0;
    bus2.in_valid = 1; bus2.in_rd = 5'd0; bus2.in_ctrl = 2'b11; bus2.in_data = 128'h1234;
    @(negedge clk);
    bus2.in_valid = 0;
    chk("nosup_x0_ctrl", 128'(bus2.out_ctrl), 128'(2'b11));
    chk("nosup_x0_rd", 128'(bus2.out_rd), 128'(0));
    chk("nosup_x0_data", 128'(bus2.out_data), 128'h1234);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 96'(32'h10 + i), 5'(i + 1), 2'b01, acc);
    cycle(0, 1, 0, '0, '0, '0, acc);
    cycle(0, 1, 0, '0, '0, '0, acc);
    for (int i = 1; i <= 2; i++) cycle(1, 0, 0, 96'(i), 5'(i), 2'b11, acc);
    chk("stall_occ_model", 128'(q.size()), 128'(2));
    cycle(1, 0, 0, 96'(3), 5'd3, 2'b11, acc);
    chk("third_held", 128'(acc), 128'(0));
    for (int i = 0; i < 8 && !acc; i++) cycle(1, 1, 0, 96'(3), 5'd3, 2'b11, acc);
    chk("third_accepted", 128'(acc), 128'(1));
    repeat (4) cycle(0, 1, 0, '0, '0, '0, acc);
    cycle(1, 1, 0, 96'hAB, 5'd0, 2'b11, acc);
    chk("x0_ctrl", 128'(bus.out_ctrl), 128'(2'b10));
    cycle(1, 1, 0, 96'hCD, 5'd5, 2'b11, acc);
    chk("rd5_ctrl", 128'(bus.out_ctrl), 128'(2'b11));
    cycle(0, 1, 0, '0, '0, '0, acc);
    cycle(1, 0, 0, 96'h21, 5'd7, 2'b01, acc);
    cycle(1, 0, 0, 96'h22, 5'd8, 2'b01, acc);
    cycle(1, 0, 1, 96'h23, 5'd9, 2'b01, acc);
    chk("flush_out_valid", 128'(bus.out_valid), 128'(0));
    chk("flush_occ", 128'(bus.occupancy), 128'(0));
    chk("flush_in_ready", 128'(bus.in_ready), 128'(1));
    repeat (3) cycle(0, 1, 0, '0, '0, '0, acc);
    cycle(1, 0, 0, 96'h31, 5'd1, 2'b11, acc);
    cycle(1, 0, 0, 96'h32, 5'd2, 2'b11, acc);
    #3 reset = 1;
    #1;
    chk("arst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("arst_payload", 128'({bus.out_data, bus.out_rd, bus.out_ctrl}), 128'(0));
    chk("arst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("arst_occ", 128'(bus.occupancy), 128'(0));
    q.delete();
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0,
            {$urandom, $urandom, $urandom}, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), acc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
